// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data memory.
//   size_e      : access size encoding carried on size_i
//   state_e     : request FSM states
//   LAT_MIN/MAX : legal LATENCY range; also sets the latency counter width
//   size_bytes  : number of bytes an access size touches (0 for illegal)
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;   // holds LAT_MAX-1

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality check and read formatting for one captured access.
//   addr  : decoded byte address
//   size  : access size (size_e encoding)
//   we/re : write / read request; exactly one must be set
//   uns   : zero-extend reads when 1, sign-extend when 0
//   raw   : four bytes starting at addr, little-endian (byte at addr in [7:0])
//   err   : access is illegal (op, size, alignment or range)
//   rdata : raw bytes trimmed to size and extended to 32 bits
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              we,
  input  logic              re,
  input  logic              uns,
  input  logic [31:0]       raw,
  output logic              err,
  output logic [31:0]       rdata
);

  logic [32:0] end_addr;   // one past the last byte touched
  logic        misalign;

  always_comb begin
    end_addr = 33'(addr) + 33'(size_bytes(size));
    misalign = ((size == SZ_HALF) && addr[0]) ||
               ((size == SZ_WORD) && (addr[1:0] != 2'b00));
    err      = (we == re) || (size == SZ_BAD) || misalign ||
               (end_addr > 33'(DEPTH));

    case (size)
      SZ_BYTE: rdata = {{24{~uns & raw[7]}},  raw[7:0]};
      SZ_HALF: rdata = {{16{~uns & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/data_memory_mc.sv
// Byte-addressed, little-endian data memory with a fixed multi-cycle latency.
// A request accepted in IDLE is captured whole; ack_o pulses LATENCY cycles
// after the accept edge, and writes / data_o load happen on the edge that
// ends the ack cycle. Requests arriving while busy are dropped.
//   clk_i, rst_i        : clock, async active-low reset
//   req_i               : request valid (sampled only in IDLE)
//   MemWrite_i/MemRead_i: operation select
//   addr_i              : byte address, bits at/above ADDR_W ignored
//   size_i, unsigned_i  : access size and read extension
//   data_i              : right-aligned write data
//   busy_o, ack_o, err_o: in flight / completion pulse / rejected (with ack)
//   data_o              : last successful read result
module data_memory_mc
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        MemWrite_i,
  input  logic        MemRead_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] data_o
);

  localparam int NUM_LANES = 4;
  localparam int MW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT       = (LATENCY < LAT_MIN) ? LAT_MIN :
                             (LATENCY > LAT_MAX) ? LAT_MAX : LATENCY;

  logic [7:0] memory [0:DEPTH-1];

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q, re_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic                                chk_err;
  logic [31:0]                         rdata;
  logic                                commit;
  logic [NUM_LANES-1:0][ADDR_W:0]      lane_addr;
  logic [NUM_LANES-1:0][MW-1:0]        lane_idx;
  logic [NUM_LANES-1:0]                lane_ok;
  logic [NUM_LANES-1:0]                lane_we;
  logic [NUM_LANES-1:0][7:0]           raw;
  logic                                unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_W];

  // Commit edge: the edge that closes the ack cycle.
  assign commit = (state == ST_WAIT) && (cnt == '0);

  // Byte lanes: lane i covers addr_q+i. Lanes past the end of the array read
  // as zero; they can only matter for accesses the checker already rejects.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_addr[i] = {1'b0, addr_q} + (ADDR_W+1)'(i);
    assign lane_ok[i]   = lane_addr[i] < (ADDR_W+1)'(DEPTH);
    assign lane_idx[i]  = lane_addr[i][MW-1:0];
    assign raw[i]       = lane_ok[i] ? memory[lane_idx[i]] : 8'h00;
    assign lane_we[i]   = commit && we_q && !chk_err &&
                          (3'(i) < size_bytes(size_q));
  end

  dmem_access_check #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_check (
    .addr  (addr_q),
    .size  (size_q),
    .we    (we_q),
    .re    (re_q),
    .uns   (uns_q),
    .raw   (raw),
    .err   (chk_err),
    .rdata (rdata)
  );

  // Storage is deliberately outside the reset domain. A reset during WAIT
  // drops state to IDLE, so commit never fires for the aborted request.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NUM_LANES; i++)
      if (lane_we[i]) memory[lane_idx[i]] <= wdata_q[i*8 +: 8];
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      busy_o  <= 1'b0;
      ack_o   <= 1'b0;
      data_o  <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          ack_o <= 1'b0;
          if (req_i) begin
            we_q    <= MemWrite_i;
            re_q    <= MemRead_i;
            uns_q   <= unsigned_i;
            size_q  <= size_i;
            addr_q  <= addr_i[ADDR_W-1:0];
            wdata_q <= data_i;
            cnt     <= CNT_W'(LAT-1);
            state   <= ST_WAIT;
            busy_o  <= 1'b1;
            ack_o   <= (LAT == 1);   // counter starts at 0 only for LATENCY 1
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            ack_o  <= 1'b0;
            if (re_q && !chk_err) data_o <= rdata;
          end else begin
            cnt   <= cnt - 1'b1;
            ack_o <= (cnt == CNT_W'(1));
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Captured request is stable for the whole WAIT, so gating is glitch-free.
  assign err_o = ack_o & chk_err;

endmodule

// File: tb/tb_data_memory_mc.sv
// Directed bench for data_memory_mc: a vector table of single accesses
// (latency, error flag, data_o after commit), then hand-written sequences for
// held-request throughput and reset during an in-flight write.
module tb_data_memory_mc;
  localparam int ADDR_W  = 11;     // wide enough that address DEPTH decodes
  localparam int DEPTH   = 1024;
  localparam int LATENCY = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic        MemRead_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [1:0]  size_i = '0;
  logic        unsigned_i = 1'b0;
  logic [31:0] data_i = '0;
  logic        busy_o, ack_o, err_o;
  logic [31:0] data_o;

  int checks = 0;
  int fails  = 0;

  data_memory_mc #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .MemWrite_i(MemWrite_i),
    .MemRead_i(MemRead_i), .addr_i(addr_i), .size_i(size_i),
    .unsigned_i(unsigned_i), .data_i(data_i), .busy_o(busy_o),
    .ack_o(ack_o), .err_o(err_o), .data_o(data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        we, re;
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        u;
    logic [31:0] d;
    logic        e_err;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One access: accept, scramble inputs during WAIT, wait for ack (bounded),
  // then step past the commit edge so data_o/memory can be sampled.
  task automatic access(input logic we, input logic re, input logic [31:0] a,
                        input logic [1:0] sz, input logic u, input logic [31:0] d,
                        output int lat, output logic e,
                        output int busy_bad, output int err_bad);
    busy_bad = 0; err_bad = 0; lat = -1; e = 1'bx;
    @(negedge clk_i);
    req_i = 1'b1; MemWrite_i = we; MemRead_i = re; addr_i = a;
    size_i = sz; unsigned_i = u; data_i = d;
    @(posedge clk_i);
    #1;
    req_i = 1'b0; MemWrite_i = ~we; MemRead_i = ~re; addr_i = $urandom;
    size_i = 2'($urandom); unsigned_i = ~u; data_i = $urandom;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk_i);
      if (err_o && !ack_o) err_bad++;
      if (!busy_o) busy_bad++;
      if (ack_o) begin
        lat = n; e = err_o;
        break;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  int   lat, bb, eb, bb_tot, eb_tot, acks, blow;
  logic e;

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.memory[i] = 8'h00;

    vecs[0]  = '{"w_word0",   1, 0, 32'd0,        2'd2, 0, 32'h0000000A, 0, 32'h00000000};
    vecs[1]  = '{"r_word0",   0, 1, 32'd0,        2'd2, 0, 32'h0,        0, 32'h0000000A};
    vecs[2]  = '{"w_byte5",   1, 0, 32'd5,        2'd0, 0, 32'h12345680, 0, 32'h0000000A};
    vecs[3]  = '{"r_byte5s",  0, 1, 32'd5,        2'd0, 0, 32'h0,        0, 32'hFFFFFF80};
    vecs[4]  = '{"r_byte5u",  0, 1, 32'd5,        2'd0, 1, 32'h0,        0, 32'h00000080};
    vecs[5]  = '{"r_word4",   0, 1, 32'd4,        2'd2, 0, 32'h0,        0, 32'h00008000};
    vecs[6]  = '{"r_half3",   0, 1, 32'd3,        2'd1, 0, 32'h0,        1, 32'h00008000};
    vecs[7]  = '{"w_word6",   1, 0, 32'd6,        2'd2, 0, 32'h11111111, 1, 32'h00008000};
    vecs[8]  = '{"size3",     0, 1, 32'd0,        2'd3, 0, 32'h0,        1, 32'h00008000};
    vecs[9]  = '{"we_and_re", 1, 1, 32'd0,        2'd2, 0, 32'h22222222, 1, 32'h00008000};
    vecs[10] = '{"no_op",     0, 0, 32'd0,        2'd2, 0, 32'h0,        1, 32'h00008000};
    vecs[11] = '{"w_top",     1, 0, 32'd1020,     2'd2, 0, 32'hCAFEF00D, 0, 32'h00008000};
    vecs[12] = '{"r_top",     0, 1, 32'd1020,     2'd2, 0, 32'h0,        0, 32'hCAFEF00D};
    vecs[13] = '{"r_depth",   0, 1, 32'd1024,     2'd2, 0, 32'h0,        1, 32'hCAFEF00D};
    vecs[14] = '{"r_half_hi", 0, 1, 32'd1022,     2'd1, 0, 32'h0,        0, 32'hFFFFCAFE};
    vecs[15] = '{"r_byte_lst",0, 1, 32'd1023,     2'd0, 1, 32'h0,        0, 32'h000000CA};
    vecs[16] = '{"r_alias",   0, 1, 32'hFFFFF800, 2'd2, 0, 32'h0,        0, 32'h0000000A};

    // reset state
    repeat (3) @(negedge clk_i);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_ack",  32'(ack_o),  32'd0);
    chk("rst_err",  32'(err_o),  32'd0);
    chk("rst_data", data_o,      32'd0);
    rst_i = 1'b1;

    bb_tot = 0; eb_tot = 0;
    foreach (vecs[i]) begin
      access(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].sz, vecs[i].u,
             vecs[i].d, lat, e, bb, eb);
      bb_tot += bb; eb_tot += eb;
      chk({vecs[i].name, "_lat"},  32'(lat), 32'(LATENCY));
      chk({vecs[i].name, "_err"},  32'(e),   32'(vecs[i].e_err));
      chk({vecs[i].name, "_data"}, data_o,   vecs[i].e_data);
    end
    chk("busy_in_wait", 32'(bb_tot), 32'd0);
    chk("err_no_ack",   32'(eb_tot), 32'd0);

    chk("mem0", 32'(dut.memory[0]), 32'h0A);
    chk("mem1_3", {8'h0, dut.memory[1], dut.memory[2], dut.memory[3]}, 32'h0);
    chk("mem4_7", {dut.memory[4], dut.memory[5], dut.memory[6], dut.memory[7]}, 32'h00800000);
    chk("mem8_9", {16'h0, dut.memory[8], dut.memory[9]}, 32'h0);
    chk("mem_top", {dut.memory[1023], dut.memory[1022], dut.memory[1021], dut.memory[1020]},
        32'hCAFEF00D);

    // req_i held for 12 cycles: accepts at edges 0, 5, 10 -> 2 acks inside window
    @(negedge clk_i);
    req_i = 1'b1; MemWrite_i = 1'b0; MemRead_i = 1'b1; addr_i = 32'd0;
    size_i = 2'd2; unsigned_i = 1'b0;
    acks = 0; blow = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
      if (!busy_o) blow++;
    end
    req_i = 1'b0;
    chk("held_acks", 32'(acks), 32'd2);
    chk("held_busy_low", 32'(blow), 32'd2);
    begin : drain
      int n;
      n = 0;
      while (busy_o && n < 20) begin
        @(negedge clk_i);
        n++;
      end
      chk("held_drain", 32'(busy_o), 32'd0);
    end
    chk("held_data", data_o, 32'h0000000A);

    // reset two cycles into an in-flight write
    @(negedge clk_i);
    req_i = 1'b1; MemWrite_i = 1'b1; MemRead_i = 1'b0; addr_i = 32'd8;
    size_i = 2'd2; unsigned_i = 1'b0; data_i = 32'hDEADBEEF;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1 chk("abort_busy_async", 32'(busy_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'd0);
    chk("abort_data", data_o, 32'd0);
    chk("abort_mem", {dut.memory[11], dut.memory[10], dut.memory[9], dut.memory[8]}, 32'h0);
    access(1'b0, 1'b1, 32'd1020, 2'd2, 1'b0, 32'h0, lat, e, bb, eb);
    chk("post_rst_lat",  32'(lat), 32'(LATENCY));
    chk("post_rst_err",  32'(e),   32'd0);
    chk("post_rst_data", data_o,   32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/data_memory_mc.md
DATA_MEMORY_MC -- requirements
Module: data_memory_mc

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, byte-address width used for decode.
REQ-002 SHALL have parameter DEPTH, default 1024, memory size in bytes; a multiple of 4 and at most 2**ADDR_W.
REQ-003 SHALL have parameter LATENCY, default 4, cycles from accept to ack; legal range 1..15.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, request valid.
REQ-007 SHALL have port MemWrite_i, input, 1, write request.
REQ-008 SHALL have port MemRead_i, input, 1, read request.
REQ-009 SHALL have port addr_i, input, 32, byte address; bits above ADDR_W ignored.
REQ-010 SHALL have port size_i, input, 2, access size: 0=byte, 1=half, 2=word, 3=illegal.
REQ-011 SHALL have port unsigned_i, input, 1, zero-extend reads when 1, sign-extend when 0.
REQ-012 SHALL have port data_i, input, 32, write data, right-aligned.
REQ-013 SHALL have port busy_o, output, 1, request in flight.
REQ-014 SHALL have port ack_o, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port err_o, output, 1, valid with ack_o; request rejected.
REQ-016 SHALL have port data_o, output, 32, read result; holds until next successful read.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and WAIT.
REQ-018 In IDLE, req_i=1 SHALL be accepted; all request inputs SHALL be captured; the FSM SHALL go to WAIT with the latency counter set to LATENCY-1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; ack_o SHALL be 1 in the cycle the counter is 0, after which the FSM SHALL return to IDLE. Result: ack exactly LATENCY cycles after the accept edge.
REQ-020 busy_o SHALL be 1 throughout WAIT; req_i while busy SHALL be ignored, not queued.
REQ-021 A new request SHALL be acceptable in the cycle after ack_o, so back-to-back throughput is one access per LATENCY+1 cycles.
REQ-022 Storage SHALL be byte-wide and little-endian: byte addr holds bits 7:0.
REQ-023 Write SHALL store the low 1, 2 or 4 bytes of data_i per size_i, committed at the ack edge only.
REQ-024 Read SHALL assemble bytes little-endian, extend to 32 bits per unsigned_i, and load data_o at the ack edge.
REQ-025 Error conditions SHALL be: MemWrite_i and MemRead_i both set or both clear; size_i=3; half not 2-aligned; word not 4-aligned; addr + size - 1 >= DEPTH.
REQ-026 An erroring request SHALL still complete with normal latency, with ack_o=1, err_o=1, memory unchanged and data_o unchanged.
REQ-027 err_o SHALL be 0 whenever ack_o=0.
REQ-028 Capture SHALL be at accept; input changes during WAIT SHALL have no effect.

Reset
REQ-029 rst_i=0 SHALL asynchronously force: FSM to IDLE, counter 0, busy_o=0, ack_o=0, err_o=0, data_o=0.
REQ-030 Memory contents SHALL NOT be cleared by reset; benches preload via hierarchical access to array memory.
REQ-031 Reset during WAIT SHALL abort the request: no write, no ack, after release.
REQ-032 Release SHALL take effect on the first clk_i edge with rst_i=1.

Structure
REQ-033 Size encodings and the LATENCY range limit SHALL live in shared package dmem_pkg.
REQ-034 Alignment, range and extension logic SHALL be one combinational sub-module, dmem_access_check, with outputs err and a formatted read word.
REQ-035 The byte array SHALL be named memory, indexed [0:DEPTH-1].

Verification
REQ-036 Word write of 0x0000000A to addr 0, then word read -> ack 4 cycles after each accept; data_o=0x0000000A; memory[0]=0x0A, memory[1..3]=0.
REQ-037 Byte write of 0x80 to addr 5: read byte signed -> 0xFFFFFF80; read byte unsigned -> 0x00000080; word read at 4 -> 0x00008000.
REQ-038 Half read at addr 3, word write at addr 6, and size_i=3 -> each gives ack with err_o=1; memory and data_o unchanged.
REQ-039 Word write at DEPTH-4 -> ok; word read at DEPTH -> err_o=1.
REQ-040 req_i held high for 12 cycles with LATENCY=4 -> exactly 2 acks; busy_o low only on the accept-ready cycles.
REQ-041 rst_i pulsed low 2 cycles after accepting a word write of 0xDEADBEEF to addr 8 -> no ack; memory[8..11] unchanged; data_o=0; a new request is accepted after release.
